// File: rtl/nibble_link_tx_ctrl_pkg.sv
// Shared types and helpers for the nibble link controllers (TX here, RX on FPGA2).
package nibble_link_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    REQ     = 2'd2,
    RELEASE = 2'd3
  } tx_state_e;

  // Bits needed to hold every value in 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/nibble_link_tx_ctrl_if.sv
// Processor-side word handshake plus the 4-bit strobe/ack pin bundle toward FPGA2.
interface nibble_link_tx_if
  import nibble_link_pkg::*;
#(
  parameter int WORD_W = 16
);
  // A word moves when tx_valid && tx_ready at a rising clock edge; tx_valid
  // while tx_ready is low is ignored, nothing is queued.
  logic [WORD_W-1:0]   tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic [NIBBLE_W-1:0] link_data;
  logic                link_strobe;
  logic                link_ack;
  logic                busy;
  logic                done;
  logic                err;

  modport slave (
    input  tx_data, tx_valid, link_ack,
    output tx_ready, link_data, link_strobe, busy, done, err
  );

  modport master (
    output tx_data, tx_valid, link_ack,
    input  tx_ready, link_data, link_strobe, busy, done, err
  );
endinterface

// File: rtl/nibble_link_tx_ctrl_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level; shared with the RX side.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  // Fewer than two flops gives no metastability protection, so clamp upward.
  localparam int S = (STAGES < 2) ? 2 : STAGES;

  logic [S-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[S-2:0], d};
  end

  assign q = ff[S-1];
endmodule

// File: rtl/nibble_link_tx_ctrl.sv
// Sends one word per accept over the 4-bit strobe/ack link, most significant nibble
// first, with done and sticky-timeout reporting.
module nibble_link_tx_ctrl
  import nibble_link_pkg::*;
#(
  parameter int WORD_W      = 16,
  parameter int ACK_TIMEOUT = 1023,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_clk,
  input  logic            reset_reset_n,
  nibble_link_tx_if.slave link,
  output logic [1:0]      state_dbg
);
  localparam int NIBBLES = WORD_W / NIBBLE_W;
  localparam int CNT_W   = cnt_width(NIBBLES);
  localparam int TO_W    = cnt_width(ACK_TIMEOUT);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NIBBLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(ACK_TIMEOUT);

  localparam logic [1:0] S_IDLE    = 2'(IDLE);
  localparam logic [1:0] S_SETUP   = 2'(SETUP);
  localparam logic [1:0] S_REQ     = 2'(REQ);
  localparam logic [1:0] S_RELEASE = 2'(RELEASE);

  logic [1:0]          state;
  logic [WORD_W-1:0]   shreg;
  logic [CNT_W-1:0]    nib_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic [NIBBLE_W-1:0] data_q;
  logic                strobe_q;
  logic                done_q;
  logic                err_q;
  logic                ack;
  logic                timed_out;

  sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .d     (link.link_ack),
    .q     (ack)
  );

  // The wait in progress expires on the edge where the counter would reach ACK_TIMEOUT.
  assign timed_out = (to_cnt >= TO_LAST);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state    <= S_IDLE;
      shreg    <= '0;
      nib_cnt  <= '0;
      to_cnt   <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (link.tx_valid) begin
            shreg   <= link.tx_data;
            nib_cnt <= CNT_LOAD;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            to_cnt  <= '0;
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          // Present the nibble for at least one cycle and only after any stale ack is gone.
          data_q <= shreg[WORD_W-1 -: NIBBLE_W];
          if (!ack && to_cnt != '0) begin
            strobe_q <= 1'b1;
            to_cnt   <= '0;
            state    <= S_REQ;
          end else if (timed_out) begin
            data_q <= '0;
            err_q  <= 1'b1;
            to_cnt <= '0;
            state  <= S_IDLE;
          end
        end
        S_REQ: begin
          if (ack) begin
            strobe_q <= 1'b0;
            to_cnt   <= '0;
            state    <= S_RELEASE;
          end else if (timed_out) begin
            strobe_q <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b1;
            to_cnt   <= '0;
            state    <= S_IDLE;
          end
        end
        default: begin
          if (!ack) begin
            shreg   <= shreg << NIBBLE_W;
            nib_cnt <= nib_cnt - 1'b1;
            to_cnt  <= '0;
            if (nib_cnt == CNT_ONE) begin
              done_q <= 1'b1;
              state  <= S_IDLE;
            end else begin
              state  <= S_SETUP;
            end
          end else if (timed_out) begin
            data_q <= '0;
            err_q  <= 1'b1;
            to_cnt <= '0;
            state  <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign link.tx_ready    = (state == S_IDLE);
  assign link.busy        = (state != S_IDLE);
  assign link.link_data   = data_q;
  assign link.link_strobe = strobe_q;
  assign link.done        = done_q;
  assign link.err         = err_q;
  assign state_dbg        = state;
endmodule

// File: tb/tb_nibble_link_tx_ctrl.sv
// Directed plus randomized bench: a nibble-queue scoreboard checks the link bus, a peer
// model answers strobes, and a second instance with a short timeout covers abort.
module tb_nibble_link_tx_ctrl;
  import nibble_link_pkg::*;

  localparam int B_TIMEOUT = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nibble_link_tx_if #(.WORD_W(16)) a_if ();
  nibble_link_tx_if #(.WORD_W(16)) b_if ();

  logic [1:0] a_state;
  logic [1:0] b_state;
  logic       peer_ack  = 1'b0;
  logic       stale_ack = 1'b0;
  int         peer_dly  = 3;

  assign a_if.link_ack = peer_ack | stale_ack;
  assign b_if.link_ack = 1'b0;

  nibble_link_tx_ctrl #(.WORD_W(16)) dut_a (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .link          (a_if),
    .state_dbg     (a_state)
  );

  nibble_link_tx_ctrl #(.WORD_W(16), .ACK_TIMEOUT(B_TIMEOUT)) dut_b (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .link          (b_if),
    .state_dbg     (b_state)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a word becomes its nibbles, most significant first.
  logic [3:0] exp_q[$];
  task automatic push_word(input logic [15:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(4'((w >> (4 * i)) & 16'hF));
  endtask

  // Peer on FPGA2: ack peer_dly cycles after strobe rises, release peer_dly after it falls.
  always begin
    @(posedge a_if.link_strobe);
    repeat (peer_dly) @(posedge clk);
    #1 peer_ack = 1'b1;
    wait (a_if.link_strobe == 1'b0);
    repeat (peer_dly) @(posedge clk);
    #1 peer_ack = 1'b0;
  end

  // Scoreboard: each strobe pulse consumes one expected nibble, held for the whole pulse.
  logic       prev_strobe = 1'b0;
  logic [3:0] cur_nib     = 4'h0;
  int         pulses      = 0;
  always @(negedge clk) begin
    if (a_if.link_strobe === 1'b1 && prev_strobe === 1'b0) begin
      pulses++;
      check("pending_nibble", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        cur_nib = exp_q.pop_front();
        check("nibble", a_if.link_data, cur_nib);
      end
    end else if (a_if.link_strobe === 1'b1) begin
      check("nibble_hold", a_if.link_data, cur_nib);
    end
    prev_strobe = a_if.link_strobe;
  end

  task automatic send_a(input logic [15:0] w);
    @(negedge clk);
    a_if.tx_data  = w;
    a_if.tx_valid = 1'b1;
    push_word(w);
    @(posedge clk);
    #1 a_if.tx_valid = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int n;
    n = 0;
    while (a_if.done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, a_if.done, 1);
    check({tag, "_ready"}, a_if.tx_ready, 1);
    check({tag, "_err"}, a_if.err, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          base;
  int          n;
  int          hi;
  logic        seen;
  logic [15:0] w;

  initial begin
    a_if.tx_data = '0; a_if.tx_valid = 1'b0;
    b_if.tx_data = '0; b_if.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", a_if.tx_ready, 1);
    check("rst_busy", a_if.busy, 0);
    check("rst_done", a_if.done, 0);
    check("rst_err", a_if.err, 0);
    check("rst_strobe", a_if.link_strobe, 0);
    check("rst_data", a_if.link_data, 0);
    check("rst_state", a_state, IDLE);
    check("rst_b_state", b_state, IDLE);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal word with latency checks.
    base = pulses;
    send_a(16'hA5C3);
    check("acc_busy", a_if.busy, 1);
    check("acc_strobe", a_if.link_strobe, 0);
    @(posedge clk); #1;
    check("lat_data", a_if.link_data, 4'hA);
    check("lat_strobe_low", a_if.link_strobe, 0);
    @(posedge clk); #1;
    check("lat_strobe_high", a_if.link_strobe, 1);
    wait_done_a("nominal");
    check("nominal_pulses", pulses - base, 4);
    check("nominal_drained", exp_q.size(), 0);
    check("nominal_last_nibble", a_if.link_data, 4'h3);

    // Stale ack held high across the accept.
    stale_ack = 1'b1;
    repeat (4) @(negedge clk);
    base = pulses;
    send_a(16'h1234);
    check("stale_done_clear", a_if.done, 0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (a_if.link_strobe !== 1'b0) seen = 1'b1;
    end
    check("stale_no_strobe", seen, 0);
    check("stale_in_setup", a_state, SETUP);
    stale_ack = 1'b0;
    wait_done_a("stale");
    check("stale_pulses", pulses - base, 4);
    check("stale_drained", exp_q.size(), 0);

    // Back-to-back words with tx_valid held high.
    base = pulses;
    push_word(16'h0001);
    push_word(16'hFFFF);
    @(negedge clk);
    a_if.tx_data  = 16'h0001;
    a_if.tx_valid = 1'b1;
    @(posedge clk); #1;
    a_if.tx_data = 16'hFFFF;
    check("b2b_first_accept", a_if.busy, 1);
    check("b2b_done_cleared", a_if.done, 0);
    n = 0;
    while (a_if.tx_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("b2b_ready_again", a_if.tx_ready, 1);
    check("b2b_done_first", a_if.done, 1);
    check("b2b_pulses_first", pulses - base, 4);
    @(posedge clk); #1;
    a_if.tx_valid = 1'b0;
    check("b2b_second_accept", a_if.busy, 1);
    check("b2b_done_drop", a_if.done, 0);
    wait_done_a("b2b");
    check("b2b_pulses", pulses - base, 8);
    check("b2b_drained", exp_q.size(), 0);

    // Random words; tx_valid/tx_data churn while busy must be ignored.
    for (int k = 0; k < 5; k++) begin
      peer_dly = $urandom_range(0, 4);
      w        = 16'($urandom);
      base     = pulses;
      send_a(w);
      n = 0;
      while (n < 400) begin
        @(negedge clk);
        n++;
        if (a_if.tx_ready === 1'b1) begin
          a_if.tx_valid = 1'b0;
          break;
        end
        a_if.tx_valid = 1'($urandom_range(0, 1));
        a_if.tx_data  = 16'($urandom);
      end
      check("rand_done", a_if.done, 1);
      check("rand_err", a_if.err, 0);
      check("rand_pulses", pulses - base, 4);
      check("rand_drained", exp_q.size(), 0);
    end

    // Reset while the second nibble's strobe is high.
    peer_dly = 3;
    repeat (8) @(negedge clk);
    base = pulses;
    send_a(16'hBEEF);
    n = 0;
    while (!((pulses - base) == 2 && a_if.link_strobe === 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached", pulses - base, 2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_strobe", a_if.link_strobe, 0);
    check("mid_rst_data", a_if.link_data, 0);
    check("mid_rst_ready", a_if.tx_ready, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", a_if.tx_ready, 1);
    check("post_rst_done", a_if.done, 0);
    check("post_rst_err", a_if.err, 0);
    repeat (12) @(negedge clk);

    // Timeout on the short-timeout instance whose peer never answers.
    @(negedge clk);
    b_if.tx_data  = 16'h5A5A;
    b_if.tx_valid = 1'b1;
    @(posedge clk);
    #1 b_if.tx_valid = 1'b0;
    check("to_accept", b_if.busy, 1);
    n = 0;
    while (b_if.link_strobe !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("to_strobe_seen", b_if.link_strobe, 1);
    check("to_req_data", b_if.link_data, 4'h5);
    hi = 0;
    n  = 0;
    while (b_if.link_strobe === 1'b1 && n < 100) begin
      hi++;
      @(negedge clk);
      n++;
    end
    check("to_strobe_cycles", hi, B_TIMEOUT);
    check("to_err", b_if.err, 1);
    check("to_strobe_low", b_if.link_strobe, 0);
    check("to_data_zero", b_if.link_data, 0);
    check("to_done", b_if.done, 0);
    check("to_ready", b_if.tx_ready, 1);

    @(negedge clk);
    b_if.tx_data  = 16'h0F0F;
    b_if.tx_valid = 1'b1;
    @(posedge clk);
    #1 b_if.tx_valid = 1'b0;
    check("to_err_cleared", b_if.err, 0);
    check("to_reaccept_busy", b_if.busy, 1);
    n = 0;
    while (b_if.tx_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("to_second_err", b_if.err, 1);
    check("to_second_done", b_if.done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
